// File: rtl/iob_cache_line_fill_pkg.sv
// ----------------------------------------------------------------------------
// iob_cache_line_fill_pkg
// Shared definitions for the cache line-fill block:
//   - fill_state_e : FSM state encoding (IDLE/REQ/FILL/WRITE)
//   - calc_line2be_w / calc_la_w / calc_rd_addr_w : width derivations shared
//     with the read and write channels of the cache back-end.
// ----------------------------------------------------------------------------
package iob_cache_line_fill_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        FILL  = 2'd2,
        WRITE = 2'd3
    } fill_state_e;

    // log2 of back-end beats per cache line
    function automatic int calc_line2be_w(input int word_offset_w, input int data_w,
                                          input int be_data_w);
        return word_offset_w - $clog2(be_data_w / data_w);
    endfunction

    // line-address width: byte address minus beat byte offset minus beat index
    function automatic int calc_la_w(input int addr_w, input int be_data_w,
                                     input int line2be_w);
        return addr_w - $clog2(be_data_w / 8) - line2be_w;
    endfunction

    // beat-index port width; a single-beat line still carries a 1-bit index
    function automatic int calc_rd_addr_w(input int line2be_w);
        return (line2be_w > 0) ? line2be_w : 1;
    endfunction

endpackage

// File: rtl/iob_cache_line_fill_if.sv
// ----------------------------------------------------------------------------
// iob_cache_line_fill_if
// Bundles every non-clock signal of the line-fill block.
//   req_*      : miss request handshake from the cache controller
//   replace_*  : replace request / busy to and from the AXI read channel
//   read_*     : beats returned by the read channel
//   line_*     : whole-line write into the cache data memory
//   fwd_*      : critical-word forward to the front-end
// Modports: slave  = the line-fill block itself
//           master = controller / read channel / data memory side
// ----------------------------------------------------------------------------
interface iob_cache_line_fill_if #(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int BE_DATA_W     = 32,
    parameter int WORD_OFFSET_W = 2,
    parameter int NWAYS_W       = 1
);
    import iob_cache_line_fill_pkg::*;

    localparam int LINE2BE_W = calc_line2be_w(WORD_OFFSET_W, DATA_W, BE_DATA_W);
    localparam int LA_W      = calc_la_w(ADDR_W, BE_DATA_W, LINE2BE_W);
    localparam int RD_ADDR_W = calc_rd_addr_w(LINE2BE_W);
    localparam int LINE_W    = DATA_W << WORD_OFFSET_W;

    logic                     req_valid_i;
    logic                     req_ready_o;
    logic [LA_W-1:0]          req_addr_i;
    logic [WORD_OFFSET_W-1:0] req_word_i;
    logic [NWAYS_W-1:0]       req_way_i;
    logic                     replace_valid_o;
    logic [LA_W-1:0]          replace_addr_o;
    logic                     replace_i;
    logic                     read_valid_i;
    logic [RD_ADDR_W-1:0]     read_addr_i;
    logic [BE_DATA_W-1:0]     read_rdata_i;
    logic                     line_we_o;
    logic [NWAYS_W-1:0]       line_way_o;
    logic [LA_W-1:0]          line_addr_o;
    logic [LINE_W-1:0]        line_wdata_o;
    logic                     fwd_valid_o;
    logic [DATA_W-1:0]        fwd_rdata_o;

    modport slave (
        input  req_valid_i, req_addr_i, req_word_i, req_way_i,
        input  replace_i, read_valid_i, read_addr_i, read_rdata_i,
        output req_ready_o, replace_valid_o, replace_addr_o,
        output line_we_o, line_way_o, line_addr_o, line_wdata_o,
        output fwd_valid_o, fwd_rdata_o
    );

    modport master (
        output req_valid_i, req_addr_i, req_word_i, req_way_i,
        output replace_i, read_valid_i, read_addr_i, read_rdata_i,
        input  req_ready_o, replace_valid_o, replace_addr_o,
        input  line_we_o, line_way_o, line_addr_o, line_wdata_o,
        input  fwd_valid_o, fwd_rdata_o
    );

endinterface

// File: rtl/iob_cache_line_fill_line_buf.sv
// ----------------------------------------------------------------------------
// iob_cache_line_fill_line_buf
// 2**LINE2BE_W x BE_DATA_W line buffer.
//   clk_i, arst_n_i : clock, asynchronous active-low clear of every slot
//   we_i, idx_i     : write strobe and beat slot (ignored when one beat/line)
//   wdata_i         : beat data
//   line_o          : flat line, beat k in [k*BE_DATA_W +: BE_DATA_W]
// ----------------------------------------------------------------------------
module iob_cache_line_fill_line_buf #(
    parameter int BE_DATA_W = 32,
    parameter int LINE2BE_W = 2,
    parameter int IDX_W     = 2
) (
    input  logic                               clk_i,
    input  logic                               arst_n_i,
    input  logic                               we_i,
    input  logic [IDX_W-1:0]                   idx_i,
    input  logic [BE_DATA_W-1:0]               wdata_i,
    output logic [(BE_DATA_W<<LINE2BE_W)-1:0]  line_o
);

    localparam int NBEATS = 32'd1 << LINE2BE_W;

    for (genvar k = 0; k < NBEATS; k++) begin : g_beat
        logic [BE_DATA_W-1:0] beat_r;
        logic                 hit_s;

        // single-beat lines always land in slot 0 whatever the index says
        assign hit_s = we_i && ((LINE2BE_W == 0) || (idx_i == IDX_W'(k)));

        // one beat slot; a repeated index simply overwrites
        always_ff @(posedge clk_i or negedge arst_n_i) begin
            if (!arst_n_i) begin
                beat_r <= '0;
            end else if (hit_s) begin
                beat_r <= wdata_i;
            end
        end

        assign line_o[k*BE_DATA_W +: BE_DATA_W] = beat_r;
    end

endmodule

// File: rtl/iob_cache_line_fill.sv
// ----------------------------------------------------------------------------
// iob_cache_line_fill
// Takes one line miss, issues the replace request to the AXI read channel,
// gathers the returned beats into a line buffer and writes the whole line to
// the data memory in a single cycle, acknowledging the miss in that cycle.
// Ports:
//   clk_i, arst_n_i : clock, asynchronous active-low reset
//   bus (slave)     : request, read-channel, line-write and forward signals
// Build option IOB_CACHE_CRIT_WORD_FWD_EN: when defined, the missed word is
// pulsed out on fwd_valid_o/fwd_rdata_o the cycle after its beat is first
// captured; when undefined those outputs are tied low.
// ----------------------------------------------------------------------------
module iob_cache_line_fill
    import iob_cache_line_fill_pkg::*;
#(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int BE_DATA_W     = 32,
    parameter int WORD_OFFSET_W = 2,
    parameter int NWAYS_W       = 1
) (
    input  logic                  clk_i,
    input  logic                  arst_n_i,
    iob_cache_line_fill_if.slave  bus
);

    localparam int LINE2BE_W = calc_line2be_w(WORD_OFFSET_W, DATA_W, BE_DATA_W);
    localparam int LA_W      = calc_la_w(ADDR_W, BE_DATA_W, LINE2BE_W);
    localparam int RD_ADDR_W = calc_rd_addr_w(LINE2BE_W);

    fill_state_e              state_r;
    fill_state_e              next_state_s;
    logic [LA_W-1:0]          addr_r;
    logic [WORD_OFFSET_W-1:0] word_r;
    logic [NWAYS_W-1:0]       way_r;
    logic                     accept_s;
    logic                     capture_s;

    assign accept_s  = (state_r == IDLE) && bus.req_valid_i;
    // beats only count while the read channel is actually busy with our line
    assign capture_s = (state_r == FILL) && bus.read_valid_i && bus.replace_i;

    // FSM state register
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state; FILL ends on the first cycle the read channel drops busy
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE:    next_state_s = bus.req_valid_i ? REQ : IDLE;
            REQ:     next_state_s = bus.replace_i ? FILL : REQ;
            FILL:    next_state_s = bus.replace_i ? FILL : WRITE;
            WRITE:   next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // FSM outputs, decoded from state only
    always_comb begin
        bus.replace_valid_o = 1'b0;
        bus.line_we_o       = 1'b0;
        bus.req_ready_o     = 1'b0;
        case (state_r)
            REQ: begin
                bus.replace_valid_o = 1'b1;
            end
            WRITE: begin
                bus.line_we_o   = 1'b1;
                bus.req_ready_o = 1'b1;
            end
            default: begin
                bus.replace_valid_o = 1'b0;
            end
        endcase
    end

    // miss descriptor, latched once when the request is taken in IDLE
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            addr_r <= '0;
            word_r <= '0;
            way_r  <= '0;
        end else if (accept_s) begin
            addr_r <= bus.req_addr_i;
            word_r <= bus.req_word_i;
            way_r  <= bus.req_way_i;
        end
    end

    assign bus.replace_addr_o = addr_r;
    assign bus.line_addr_o    = addr_r;
    assign bus.line_way_o     = way_r;

    iob_cache_line_fill_line_buf #(
        .BE_DATA_W (BE_DATA_W),
        .LINE2BE_W (LINE2BE_W),
        .IDX_W     (RD_ADDR_W)
    ) u_line_buf (
        .clk_i    (clk_i),
        .arst_n_i (arst_n_i),
        .we_i     (capture_s),
        .idx_i    (bus.read_addr_i),
        .wdata_i  (bus.read_rdata_i),
        .line_o   (bus.line_wdata_o)
    );

`ifdef IOB_CACHE_CRIT_WORD_FWD_EN
    localparam int BEAT_WORDS = BE_DATA_W / DATA_W;

    logic              fwd_done_r;
    logic              fwd_valid_r;
    logic [DATA_W-1:0] fwd_rdata_r;
    logic [DATA_W-1:0] fwd_word_s;
    logic              crit_hit_s;
    int                slot_s;
    int                crit_beat_s;
    int                word_sel_s;

    // critical beat/word select; fwd_done_r keeps a retry from pulsing twice
    always_comb begin
        slot_s      = (LINE2BE_W == 0) ? 32'sd0 : int'(bus.read_addr_i);
        crit_beat_s = int'(word_r) / BEAT_WORDS;
        word_sel_s  = int'(word_r) % BEAT_WORDS;
        crit_hit_s  = capture_s && !fwd_done_r && (slot_s == crit_beat_s);
        fwd_word_s  = '0;
        for (int w = 0; w < BEAT_WORDS; w++) begin
            fwd_word_s = fwd_word_s |
                         ((w == word_sel_s) ? bus.read_rdata_i[w*DATA_W +: DATA_W]
                                            : {DATA_W{1'b0}});
        end
    end

    // registered one-shot forward of the critical word
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            fwd_done_r  <= 1'b0;
            fwd_valid_r <= 1'b0;
            fwd_rdata_r <= '0;
        end else begin
            if (accept_s) begin
                fwd_done_r <= 1'b0;
            end else if (crit_hit_s) begin
                fwd_done_r <= 1'b1;
            end
            fwd_valid_r <= crit_hit_s;
            if (crit_hit_s) begin
                fwd_rdata_r <= fwd_word_s;
            end
        end
    end

    assign bus.fwd_valid_o = fwd_valid_r;
    assign bus.fwd_rdata_o = fwd_rdata_r;
`else
    logic unused_word_s;

    assign unused_word_s   = ^word_r;
    assign bus.fwd_valid_o = 1'b0;
    assign bus.fwd_rdata_o = '0;
`endif

endmodule

// File: tb/tb_iob_cache_line_fill.sv
// ----------------------------------------------------------------------------
// tb_iob_cache_line_fill
// Directed bench for iob_cache_line_fill. Instance A: 32-bit beats, 4 beats
// per line. Instance B: one 128-bit beat per line. Forward expectations follow
// IOB_CACHE_CRIT_WORD_FWD_EN.
// ----------------------------------------------------------------------------
module tb_iob_cache_line_fill;

`ifdef IOB_CACHE_CRIT_WORD_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    logic clk;
    logic arst_n;

    int n_checks;
    int n_fail;
    int we_a, fwd_a, we_b, fwd_b;
    logic [127:0] prev_line_a;

    iob_cache_line_fill_if #(.ADDR_W(32), .DATA_W(32), .BE_DATA_W(32),
                             .WORD_OFFSET_W(2), .NWAYS_W(1)) a_if ();
    iob_cache_line_fill_if #(.ADDR_W(32), .DATA_W(32), .BE_DATA_W(128),
                             .WORD_OFFSET_W(2), .NWAYS_W(1)) b_if ();

    iob_cache_line_fill #(.ADDR_W(32), .DATA_W(32), .BE_DATA_W(32),
                          .WORD_OFFSET_W(2), .NWAYS_W(1)) dut_a (
        .clk_i (clk), .arst_n_i (arst_n), .bus (a_if.slave));

    iob_cache_line_fill #(.ADDR_W(32), .DATA_W(32), .BE_DATA_W(128),
                          .WORD_OFFSET_W(2), .NWAYS_W(1)) dut_b (
        .clk_i (clk), .arst_n_i (arst_n), .bus (b_if.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // pulse counters
    always @(posedge clk) begin
        if (a_if.line_we_o)   we_a  <= we_a + 1;
        if (a_if.fwd_valid_o) fwd_a <= fwd_a + 1;
        if (b_if.line_we_o)   we_b  <= we_b + 1;
        if (b_if.fwd_valid_o) fwd_b <= fwd_b + 1;
    end

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // one full miss on instance A; optional retry pass and stray beats
    task automatic fill_a(input logic [27:0] addr, input logic [1:0] word, input logic way,
                          input logic [31:0] b1, input bit retry, input logic [31:0] b2,
                          input bit stray);
        int we0, fwd0;
        bit exp_fwd;
        logic [127:0] line_exp;
        logic [31:0] bp;
        we0  = we_a;
        fwd0 = fwd_a;
        if (stray) begin
            a_if.read_valid_i = 1'b1;
            a_if.read_addr_i  = 2'd1;
            a_if.read_rdata_i = 32'hDEADBEEF;
            step();
        end
        a_if.req_valid_i = 1'b1;
        a_if.req_addr_i  = addr;
        a_if.req_word_i  = word;
        a_if.req_way_i   = way;
        step();
        check_eq("a_rv_lat", 128'(a_if.replace_valid_o), 128'(1'b1));
        check_eq("a_raddr", 128'(a_if.replace_addr_o), 128'(addr));
        step();
        check_eq("a_rv_hold", 128'(a_if.replace_valid_o), 128'(1'b1));
        if (stray) check_eq("a_stray_buf", a_if.line_wdata_o, prev_line_a);
        a_if.read_valid_i = 1'b0;
        a_if.replace_i    = 1'b1;
        step();
        check_eq("a_rv_drop", 128'(a_if.replace_valid_o), 128'(1'b0));
        for (int p = 0; p < (retry ? 2 : 1); p++) begin
            bp = (p == 0) ? b1 : b2;
            for (int k = 0; k < 4; k++) begin
                a_if.read_valid_i = 1'b1;
                a_if.read_addr_i  = k[1:0];
                a_if.read_rdata_i = bp + 32'(k);
                step();
                exp_fwd = FWD_EN && (p == 0) && (k == int'(word));
                check_eq("a_fwd_v", 128'(a_if.fwd_valid_o), 128'(exp_fwd));
                if (exp_fwd) check_eq("a_fwd_d", 128'(a_if.fwd_rdata_o), 128'(b1 + 32'(k)));
            end
        end
        bp = retry ? b2 : b1;
        for (int k = 0; k < 4; k++) line_exp[k*32 +: 32] = bp + 32'(k);
        a_if.read_valid_i = 1'b0;
        a_if.replace_i    = 1'b0;
        step();
        check_eq("a_we", 128'(a_if.line_we_o), 128'(1'b1));
        check_eq("a_ready", 128'(a_if.req_ready_o), 128'(1'b1));
        check_eq("a_wdata", a_if.line_wdata_o, line_exp);
        check_eq("a_way", 128'(a_if.line_way_o), 128'(way));
        check_eq("a_laddr", 128'(a_if.line_addr_o), 128'(addr));
        check_eq("a_fwd_end", 128'(a_if.fwd_valid_o), 128'(1'b0));
        a_if.req_valid_i = 1'b0;
        step();
        check_eq("a_we_off", 128'(a_if.line_we_o), 128'(1'b0));
        check_eq("a_ready_off", 128'(a_if.req_ready_o), 128'(1'b0));
        check_eq("a_we_cnt", 128'(we_a - we0), 128'(1));
        check_eq("a_fwd_cnt", 128'(fwd_a - fwd0), 128'(FWD_EN));
        prev_line_a = line_exp;
    endtask

    initial begin
        int we0;
        n_checks = 0; n_fail = 0;
        we_a = 0; fwd_a = 0; we_b = 0; fwd_b = 0;
        prev_line_a = '0;
        arst_n = 1'b0;
        a_if.req_valid_i = 1'b0; a_if.req_addr_i = '0; a_if.req_word_i = '0;
        a_if.req_way_i = '0; a_if.replace_i = 1'b0; a_if.read_valid_i = 1'b0;
        a_if.read_addr_i = '0; a_if.read_rdata_i = '0;
        b_if.req_valid_i = 1'b0; b_if.req_addr_i = '0; b_if.req_word_i = '0;
        b_if.req_way_i = '0; b_if.replace_i = 1'b0; b_if.read_valid_i = 1'b0;
        b_if.read_addr_i = '0; b_if.read_rdata_i = '0;
        step(); step();

        // reset state
        check_eq("rst_rv", 128'(a_if.replace_valid_o), 128'(1'b0));
        check_eq("rst_we", 128'(a_if.line_we_o), 128'(1'b0));
        check_eq("rst_ready", 128'(a_if.req_ready_o), 128'(1'b0));
        check_eq("rst_wdata", a_if.line_wdata_o, 128'h0);
        check_eq("rst_fwd", 128'(a_if.fwd_valid_o), 128'(1'b0));
        arst_n = 1'b1;
        step();

        // basic fill: beats A0..A3, critical word 2
        fill_a(28'h1A, 2'd2, 1'b1, 32'hA0, 1'b0, 32'h0, 1'b0);
        check_eq("a_line_idle", a_if.line_wdata_o, 128'h000000A3_000000A2_000000A1_000000A0);

        // slave-error retry: B values overwritten by C values
        fill_a(28'h2C, 2'd1, 1'b0, 32'hB0, 1'b1, 32'hC0, 1'b0);
        check_eq("a_retry_line", a_if.line_wdata_o, 128'h000000C3_000000C2_000000C1_000000C0);

        // single 128-bit beat, critical word 3
        we0 = we_b;
        b_if.req_valid_i = 1'b1; b_if.req_addr_i = 28'h2B;
        b_if.req_word_i = 2'd3; b_if.req_way_i = 1'b0;
        step();
        check_eq("b_rv", 128'(b_if.replace_valid_o), 128'(1'b1));
        b_if.replace_i = 1'b1;
        step();
        b_if.read_valid_i = 1'b1; b_if.read_addr_i = 1'b0;
        b_if.read_rdata_i = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
        step();
        check_eq("b_fwd_v", 128'(b_if.fwd_valid_o), 128'(FWD_EN));
        check_eq("b_fwd_d", 128'(b_if.fwd_rdata_o), FWD_EN ? 128'h01234567 : 128'h0);
        b_if.read_valid_i = 1'b0; b_if.replace_i = 1'b0;
        step();
        check_eq("b_we", 128'(b_if.line_we_o), 128'(1'b1));
        check_eq("b_ready", 128'(b_if.req_ready_o), 128'(1'b1));
        check_eq("b_wdata", b_if.line_wdata_o, 128'h01234567_89ABCDEF_FEDCBA98_76543210);
        check_eq("b_laddr", 128'(b_if.line_addr_o), 128'h2B);
        b_if.req_valid_i = 1'b0;
        step();
        check_eq("b_we_cnt", 128'(we_b - we0), 128'(1));
        check_eq("b_fwd_cnt", 128'(fwd_b), 128'(FWD_EN));

        // reset mid-fill after two beats abandons the line
        we0 = we_a;
        a_if.req_valid_i = 1'b1; a_if.req_addr_i = 28'h5E;
        a_if.req_word_i = 2'd0; a_if.req_way_i = 1'b1;
        step();
        a_if.replace_i = 1'b1;
        step();
        for (int k = 0; k < 2; k++) begin
            a_if.read_valid_i = 1'b1; a_if.read_addr_i = k[1:0];
            a_if.read_rdata_i = 32'h70 + 32'(k);
            step();
        end
        #2 arst_n = 1'b0;
        #1;
        check_eq("mrst_wdata", a_if.line_wdata_o, 128'h0);
        check_eq("mrst_laddr", 128'(a_if.line_addr_o), 128'h0);
        check_eq("mrst_way", 128'(a_if.line_way_o), 128'h0);
        check_eq("mrst_raddr", 128'(a_if.replace_addr_o), 128'h0);
        check_eq("mrst_fwd", 128'(a_if.fwd_valid_o), 128'h0);
        a_if.req_valid_i = 1'b0; a_if.replace_i = 1'b0; a_if.read_valid_i = 1'b0;
        step();
        arst_n = 1'b1;
        step(); step();
        check_eq("mrst_we_cnt", 128'(we_a - we0), 128'(0));
        check_eq("mrst_ready", 128'(a_if.req_ready_o), 128'(1'b0));
        prev_line_a = '0;

        // next request completes, then back-to-back with stray beats
        fill_a(28'h5E, 2'd0, 1'b1, 32'h80, 1'b0, 32'h0, 1'b0);
        fill_a(28'h3D, 2'd3, 1'b0, 32'h11223300, 1'b0, 32'h0, 1'b1);
        fill_a(28'hFFFFFFF, 2'd1, 1'b1, 32'h55667700, 1'b0, 32'h0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
